// File: rtl/voq_out_sched.sv
// -----------------------------------------------------------------------------
// voq_out_sched
//
// Output-side scheduler for one egress port, placed directly downstream of a
// bank of NUM_VOQ voq instances. It mirrors each VOQ's occupancy, picks a
// non-empty VOQ round-robin, pulses that VOQ's read_req_i for one cycle,
// captures the pointer it returns one cycle later, and offers the pointer
// (tagged with its source index) to the egress reader on valid/ready.
//
// Ports
//   clk              system clock
//   rst              asynchronous, active-high reset
//   voq_enq_i        copy of each VOQ's write_req_i (mirror counter input)
//   voq_rd_req_o     one-hot read_req_i to the granted VOQ (REQ cycle only)
//   voq_ptr_i        each VOQ's ptr_o
//   voq_ptr_valid_i  each VOQ's ptr_valid_o
//   out_ptr_o        dequeued pointer
//   out_src_o        index of the VOQ that supplied out_ptr_o
//   out_valid_o      out_ptr_o / out_src_o valid
//   out_ready_i      egress accepts when high together with out_valid_o
//   err_o            sticky: a granted VOQ returned ptr_valid low
//   grant_cnt_o      (VOQ_SCHED_STATS_EN only) per-VOQ 16-bit wrapping count
//                    of completed output handshakes
//
// Build option
//   VOQ_SCHED_STATS_EN  adds grant_cnt_o and its counters.
//
// ADDR_W and VOQ_DEPTH default to the system values of mem_pkg::ADDR_W and
// voq_pkg::VOQ_DEPTH; the integrating level overrides them from those packages.
// -----------------------------------------------------------------------------
module voq_out_sched #(
   parameter int NUM_VOQ   = 4,
   parameter int ADDR_W    = 12,
   parameter int VOQ_DEPTH = 8,
   parameter int SRC_W     = $clog2(NUM_VOQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_VOQ-1:0]             voq_enq_i,
   output logic [NUM_VOQ-1:0]             voq_rd_req_o,
   input  logic [NUM_VOQ-1:0][ADDR_W-1:0] voq_ptr_i,
   input  logic [NUM_VOQ-1:0]             voq_ptr_valid_i,
   output logic [ADDR_W-1:0]              out_ptr_o,
   output logic [SRC_W-1:0]               out_src_o,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic                           err_o
`ifdef VOQ_SCHED_STATS_EN
   ,
   output logic [NUM_VOQ-1:0][15:0]       grant_cnt_o
`endif
);

   localparam int CNT_W = $clog2(VOQ_DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_CAPT,
      S_HOLD
   } state_t;

   state_t             state_q, state_d;
   logic [SRC_W-1:0]   grant_q;
   logic [SRC_W-1:0]   rr_last_q;
   logic [SRC_W-1:0]   pick;
   logic [SRC_W-1:0]   idx;
   logic               any_elig;
   logic               load_grant;
   logic [NUM_VOQ-1:0] elig;
   logic [CNT_W-1:0]   cnt_q [NUM_VOQ];
   logic [CNT_W-1:0]   cnt_d [NUM_VOQ];
   logic               acc_wr;

   // Read request is decoded from state so an asynchronous reset removes it
   // in the same instant, without waiting for a clock.
   assign voq_rd_req_o = (state_q == S_REQ) ? (NUM_VOQ'(1) << grant_q) : '0;

   // Mirror occupancy: a write is dropped only when full and not read in the
   // same cycle, exactly as the VOQ itself behaves.
   always_comb begin
      // NOTE: every variable written here gets a value before any branch, so
      // no path leaves one unassigned and no latch is inferred.
      acc_wr = 1'b0;
      for (int i = 0; i < NUM_VOQ; i++) begin
         cnt_d[i] = cnt_q[i];
         elig[i]  = (cnt_q[i] != '0);
         acc_wr   = voq_enq_i[i] && ((cnt_q[i] < CNT_W'(VOQ_DEPTH)) || voq_rd_req_o[i]);
         if (acc_wr && !voq_rd_req_o[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (!acc_wr && voq_rd_req_o[i]) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
      end
   end

   // NOTE: the counter array is reset because arbitration reads it on the
   // first cycle after reset; it is a handful of flops, not a RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_VOQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_VOQ; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Round-robin: first eligible index after rr_last, wrapping.
   always_comb begin
      pick     = rr_last_q;
      idx      = rr_last_q;
      any_elig = 1'b0;
      for (int k = 1; k <= NUM_VOQ; k++) begin
         idx = SRC_W'((int'(rr_last_q) + k) % NUM_VOQ);
         if (!any_elig && elig[idx]) begin
            any_elig = 1'b1;
            pick     = idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      load_grant = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_elig) begin
               load_grant = 1'b1;
               state_d    = S_REQ;
            end
         end
         S_REQ:  state_d = S_CAPT;
         S_CAPT: state_d = voq_ptr_valid_i[grant_q] ? S_HOLD : S_IDLE;
         S_HOLD: begin
            // HOLD is only entered with out_valid_o set, so out_ready_i alone
            // marks the handshake here.
            if (out_ready_i) begin
               if (any_elig) begin
                  load_grant = 1'b1;
                  state_d    = S_REQ;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // here samples the values from before this edge, independent of order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         rr_last_q   <= SRC_W'(NUM_VOQ - 1);
         out_ptr_o   <= '0;
         out_src_o   <= '0;
         out_valid_o <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_grant) begin
            grant_q   <= pick;
            rr_last_q <= pick;
         end
         if (state_q == S_CAPT) begin
            if (voq_ptr_valid_i[grant_q]) begin
               out_ptr_o   <= voq_ptr_i[grant_q];
               out_src_o   <= grant_q;
               out_valid_o <= 1'b1;
            end else begin
               err_o <= 1'b1;
            end
         end
         if ((state_q == S_HOLD) && out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end

`ifdef VOQ_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt_o <= '0;
      end else if (out_valid_o && out_ready_i) begin
         grant_cnt_o[out_src_o] <= grant_cnt_o[out_src_o] + 16'd1;
      end
   end
`endif

endmodule
